// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard detector and SRAM access sequencer; drives IF/ID holds, flush and ID/EX bubble.
// Hazard outputs are combinational (0 cycles); superStall covers SRAM_LATENCY cycles, mem_ready one cycle later.
// superStall freezes the pipeline and masks branch flush and bubble insertion; mem_req is ignored in DONE.
module hazard_stall_ctrl #(
    parameter int SRAM_LATENCY = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        forward_en,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic        id_two_src,
    input  logic        exe_wb_en,
    input  logic        exe_mem_read,
    input  logic [4:0]  exe_dest,
    input  logic        mem_wb_en,
    input  logic [4:0]  mem_dest,
    input  logic        mem_req,
    input  logic        branch_taken,
    output logic        stall,
    output logic        loadForwardStall,
    output logic        superStall,
    output logic        flush_if_id,
    output logic        id_bubble,
    output logic        mem_ready,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] LAT  = SRAM_LATENCY[3:0];

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] stall_cnt;

    logic haz_src1, haz_src2, lu_src1, lu_src2;
    logic raw, load_use;
    logic stall_raw, lfs_raw, super_raw, ready_raw, hold;

    assign haz_src1 = (id_src1 != 5'd0) &&
                      ((exe_wb_en && (exe_dest == id_src1)) || (mem_wb_en && (mem_dest == id_src1)));
    assign haz_src2 = (id_src2 != 5'd0) &&
                      ((exe_wb_en && (exe_dest == id_src2)) || (mem_wb_en && (mem_dest == id_src2)));
    assign lu_src1  = (id_src1 != 5'd0) && exe_mem_read && (exe_dest == id_src1);
    assign lu_src2  = (id_src2 != 5'd0) && exe_mem_read && (exe_dest == id_src2);

    assign raw       = haz_src1 | (id_two_src & haz_src2);
    assign load_use  = lu_src1 | (id_two_src & lu_src2);
    assign stall_raw = ~forward_en & raw;
    assign lfs_raw   = forward_en & load_use;

    // A request seen in IDLE freezes the pipeline in that same cycle.
    always_comb begin
        super_raw = 1'b0;
        ready_raw = 1'b0;
        case (state)
            IDLE:    super_raw = mem_req;
            BUSY:    super_raw = 1'b1;
            DONE:    ready_raw = 1'b1;
            default: super_raw = 1'b0;
        endcase
    end

    assign hold = stall_raw | lfs_raw | super_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (hold && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        cnt   <= 4'd1;
                        state <= (LAT == 4'd1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 4'd1;
                    if ((cnt + 4'd1) == LAT) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Everything is held low while reset is asserted, including the combinational paths.
    assign stall            = ~rst & stall_raw;
    assign loadForwardStall = ~rst & lfs_raw;
    assign superStall       = ~rst & super_raw;
    assign mem_ready        = ~rst & ready_raw;
    assign flush_if_id      = ~rst & branch_taken & ~super_raw;
    assign id_bubble        = ~rst & (stall_raw | lfs_raw | branch_taken) & ~super_raw;
    assign stall_cycles     = rst ? 32'd0 : stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: hazard combinations, SRAM timing, branch masking, mid-access reset.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        forward_en;
    logic [4:0]  id_src1, id_src2;
    logic        id_two_src;
    logic        exe_wb_en, exe_mem_read;
    logic [4:0]  exe_dest;
    logic        mem_wb_en;
    logic [4:0]  mem_dest;
    logic        mem_req, branch_taken;
    logic        stall, loadForwardStall, superStall, flush_if_id, id_bubble, mem_ready;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    hazard_stall_ctrl #(.SRAM_LATENCY(6)) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_req(mem_req),
        .branch_taken(branch_taken), .stall(stall), .loadForwardStall(loadForwardStall),
        .superStall(superStall), .flush_if_id(flush_if_id), .id_bubble(id_bubble),
        .mem_ready(mem_ready), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        forward_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        exe_wb_en = 0; exe_mem_read = 0; exe_dest = 0;
        mem_wb_en = 0; mem_dest = 0; mem_req = 0; branch_taken = 0;
    endtask

    // Advance one cycle: inputs change just after the edge, outputs are sampled mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        // Hazard present during reset must still be masked.
        forward_en = 0; exe_wb_en = 1; exe_dest = 5; id_src1 = 5;
        branch_taken = 1; mem_req = 1;
        next_cycle();
        next_cycle();
        settle();
        check("rst_stall", {31'd0, stall}, 0);
        check("rst_super", {31'd0, superStall}, 0);
        check("rst_flush", {31'd0, flush_if_id}, 0);
        check("rst_bubble", {31'd0, id_bubble}, 0);
        check("rst_cycles", stall_cycles, 0);

        next_cycle();
        clear_inputs();
        rst = 0;
        settle();
        check("idle_ready", {31'd0, mem_ready}, 0);
        check("idle_cycles", stall_cycles, 0);

        // RAW hazard, non-forwarding mode
        forward_en = 0; exe_wb_en = 1; exe_dest = 5; id_src1 = 5;
        settle();
        check("t1_stall", {31'd0, stall}, 1);
        check("t1_bubble", {31'd0, id_bubble}, 1);
        check("t1_lfs", {31'd0, loadForwardStall}, 0);
        next_cycle();
        id_src1 = 0; exe_dest = 0;
        settle();
        check("t1_r0_stall", {31'd0, stall}, 0);
        check("t1_r0_bubble", {31'd0, id_bubble}, 0);
        next_cycle();
        exe_wb_en = 0; mem_wb_en = 1; mem_dest = 7; id_two_src = 1; id_src2 = 7;
        settle();
        check("t1_mem_src2", {31'd0, stall}, 1);
        next_cycle();
        id_two_src = 0;
        settle();
        check("t1_src2_unused", {31'd0, stall}, 0);
        next_cycle();
        id_two_src = 1; forward_en = 1;
        settle();
        check("t1_fwd_nostall", {31'd0, stall}, 0);
        check("t1_fwd_nolfs", {31'd0, loadForwardStall}, 0);

        // Load-use in forwarding mode
        next_cycle();
        clear_inputs();
        forward_en = 1; exe_mem_read = 1; exe_wb_en = 1; exe_dest = 3; id_two_src = 1; id_src2 = 3;
        settle();
        check("t2_lfs", {31'd0, loadForwardStall}, 1);
        check("t2_stall", {31'd0, stall}, 0);
        check("t2_bubble", {31'd0, id_bubble}, 1);
        next_cycle();
        exe_mem_read = 0;
        settle();
        check("t2_nold_lfs", {31'd0, loadForwardStall}, 0);
        check("t2_nold_stall", {31'd0, stall}, 0);

        // Single access, L=6: freeze for cycles 0..5, ready in 6, branch masked while frozen
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 8; i++) begin
            branch_taken = (i == 3 || i == 6);
            forward_en = 0;
            exe_wb_en = (i == 2); exe_dest = 9; id_src1 = 9;
            if (i == 7) mem_req = 0;
            settle();
            check($sformatf("t3_super_%0d", i), {31'd0, superStall}, (i < 6) ? 1 : 0);
            check($sformatf("t3_ready_%0d", i), {31'd0, mem_ready}, (i == 6) ? 1 : 0);
            if (i == 2) begin
                check("t3_stall_frozen", {31'd0, stall}, 1);
                check("t3_bubble_frozen", {31'd0, id_bubble}, 0);
            end
            if (i == 3) check("t5_flush_frozen", {31'd0, flush_if_id}, 0);
            if (i == 6) begin
                check("t5_flush_done", {31'd0, flush_if_id}, 1);
                check("t5_bubble_done", {31'd0, id_bubble}, 1);
                check("t3_cycles", stall_cycles, 6);
            end
            next_cycle();
        end
        clear_inputs();

        // Back-to-back accesses with mem_req never dropping
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 15; i++) begin
            if (i == 14) mem_req = 0;
            settle();
            check($sformatf("t4_super_%0d", i), {31'd0, superStall},
                  ((i < 6) || (i >= 7 && i < 13)) ? 1 : 0);
            check($sformatf("t4_ready_%0d", i), {31'd0, mem_ready}, (i == 6 || i == 13) ? 1 : 0);
            next_cycle();
        end
        settle();
        check("t4_cycles", stall_cycles, 12);

        // Reset in the middle of an access
        do_reset();
        mem_req = 1;
        next_cycle();
        next_cycle();
        rst = 1;
        settle();
        check("t6_super_rst", {31'd0, superStall}, 0);
        check("t6_ready_rst", {31'd0, mem_ready}, 0);
        check("t6_cycles_rst", stall_cycles, 0);
        next_cycle();
        rst = 0; mem_req = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            check($sformatf("t6_super_%0d", i), {31'd0, superStall}, 0);
            check($sformatf("t6_ready_%0d", i), {31'd0, mem_ready}, 0);
            next_cycle();
        end
        settle();
        check("t6_cycles_after", stall_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
